// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the syn_FIFO write-port arbiter.
// Holds the arbiter state enum, the stats counter width and the round-robin search.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned STAT_W = 16;

  // Widest request vector the round-robin search handles.
  localparam int unsigned RR_MAX = 32;

  // Returns the first set bit of req strictly after last, wrapping modulo n.
  // With no bit set it returns last; callers qualify the result with |req.
  function automatic logic [4:0] rr_search(input logic [RR_MAX-1:0] req,
                                           input logic [4:0]        last,
                                           input logic [5:0]        n);
    logic [5:0] sum;
    sum       = '0;
    rr_search = last;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = RR_MAX; k >= 1; k--) begin
      if (6'(k) <= n) begin
        sum = 6'(last) + 6'(k);
        if (sum >= n) begin
          sum = sum - n;
        end
        if (req[sum[4:0]]) begin
          rr_search = sum[4:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority rotator: picks the next requester after last_grant.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     pick,
  output logic               any_req
);

  always_comb begin
    pick    = IDW'(rr_search(RR_MAX'(req), 5'(last_grant), 6'(NUM_REQ)));
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the syn_FIFO write port among NUM_REQ producers in bursts.
// Optional per-requester accepted-word counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_words
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_BURST + 1);

  arb_state_t          state;
  logic [CW-1:0]       burst_cnt;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      pick;
  logic                any_req;
  logic                cur_valid;
  logic                transfer;
  logic                burst_last;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  // Unpack the flat data bus so the granted word is a plain array select.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  assign cur_valid  = req_valid[grant_id];
  assign burst_last = (burst_cnt == CW'(MAX_BURST - 1));

  // Write-port steering; gated by rst so nothing is accepted on a reset cycle.
  always_comb begin
    req_ready    = '0;
    transfer     = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state == BURST && !rst) begin
      req_ready    = NUM_REQ'(!fifo_full) << grant_id;
      transfer     = cur_valid && !fifo_full;
      fifo_wr_en   = transfer;
      fifo_wr_data = words[grant_id];
    end
  end

  // Grant FSM: one registered IDLE arbitration cycle between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      last_grant  <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id    <= pick;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (!cur_valid || (transfer && burst_last)) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_grant  <= grant_id;
            burst_cnt   <= '0;
          end else if (transfer) begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating count of accepted words per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (req_valid[i] && req_ready[i] && (cnt != {STAT_W{1'b1}})) begin
        cnt <= cnt + STAT_W'(1);
      end
    end
    assign stat_words[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
